// File: rtl/lcd_capture_pkg.sv
// Shared LCD parameters: panel defaults, capture FSM states, error flag bits.
package lcd_capture_pkg;

   localparam int unsigned LCD_RES_X = 320;
   localparam int unsigned LCD_RES_Y = 240;

   localparam int ERR_OVERRUN = 0;
   localparam int ERR_ROW_OVF = 1;
   localparam int ERR_M_STUCK = 2;

   typedef enum logic [1:0] {
      ST_SYNC = 2'd0,
      ST_LINE = 2'd1,
      ST_IDLE = 2'd2
   } cap_state_t;

   // Panel shifts the first nibble MSB-first onto the left pixel; the
   // framebuffer stores the leftmost pixel in bit 0.
   function automatic logic [7:0] bit_rev8(input logic [7:0] b);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         r[i] = b[7-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/lcd_sync_edge.sv
// Two-flop synchronizer with registered history for rise/fall pulses.
module lcd_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic s1;
   logic s2;
   logic s3;

   // Synchronizer chain plus one history flop for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= din;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign level = s2;
   assign rise  = s2 & ~s3;
   assign fall  = ~s2 & s3;

endmodule

// File: rtl/lcd_capture.sv
// Captures a 4-bit monochrome LCD panel bus into framebuffer byte writes.
//
// state | meaning
// SYNC  | waiting for a line with flm high; no writes
// LINE  | capturing nibbles of the current row
// IDLE  | row complete; further dclk falls are overruns
module lcd_capture
   import lcd_capture_pkg::*;
#(
   parameter int unsigned RES_X = LCD_RES_X,
   parameter int unsigned RES_Y = LCD_RES_Y
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  data,
   input  logic        flm,
   input  logic        lp,
   input  logic        dclk,
   input  logic        m,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        frame_done,
   output logic [2:0]  err
);

   localparam int unsigned NIBS          = RES_X / 4;
   localparam int unsigned BYTES_PER_ROW = RES_X / 8;
   localparam int unsigned NIB_W         = $clog2(NIBS + 1);
   localparam int unsigned ROW_W         = $clog2(RES_Y + 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(RES_Y - 1);
   localparam logic [NIB_W-1:0] LINE_END = NIB_W'(NIBS);

   logic [3:0] data_s1;
   logic [3:0] data_s2;

   logic flm_lvl;
   logic m_lvl;
   logic lp_rise;
   logic dclk_fall;
   logic flm_rise_unused;
   logic flm_fall_unused;
   logic m_rise_unused;
   logic m_fall_unused;
   logic lp_lvl_unused;
   logic lp_fall_unused;
   logic dclk_lvl_unused;
   logic dclk_rise_unused;

   lcd_sync_edge u_sync_flm (
      .clk(clk), .rst(rst), .din(flm),
      .level(flm_lvl), .rise(flm_rise_unused), .fall(flm_fall_unused)
   );

   lcd_sync_edge u_sync_lp (
      .clk(clk), .rst(rst), .din(lp),
      .level(lp_lvl_unused), .rise(lp_rise), .fall(lp_fall_unused)
   );

   lcd_sync_edge u_sync_dclk (
      .clk(clk), .rst(rst), .din(dclk),
      .level(dclk_lvl_unused), .rise(dclk_rise_unused), .fall(dclk_fall)
   );

   lcd_sync_edge u_sync_m (
      .clk(clk), .rst(rst), .din(m),
      .level(m_lvl), .rise(m_rise_unused), .fall(m_fall_unused)
   );

   // Data uses the same two-stage latency as dclk so the captured nibble
   // lines up with the detected falling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_s1 <= '0;
         data_s2 <= '0;
      end else begin
         data_s1 <= data;
         data_s2 <= data_s1;
      end
   end

   cap_state_t       state,   state_nx;
   logic [ROW_W-1:0] row,     row_nx;
   logic [NIB_W-1:0] nib_cnt, nib_nx;
   logic [3:0]       n0,      n0_nx;
   logic             m_last,  m_last_nx;
   logic             m_seen,  m_seen_nx;
   logic [2:0]       err_nx;
   logic             wr_en_nx;
   logic [31:0]      wr_addr_nx;
   logic [7:0]       wr_data_nx;

   // State and capture registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_SYNC;
         row     <= '0;
         nib_cnt <= '0;
         n0      <= '0;
         m_last  <= 1'b0;
         m_seen  <= 1'b0;
         err     <= '0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         state   <= state_nx;
         row     <= row_nx;
         nib_cnt <= nib_nx;
         n0      <= n0_nx;
         m_last  <= m_last_nx;
         m_seen  <= m_seen_nx;
         err     <= err_nx;
         wr_en   <= wr_en_nx;
         wr_addr <= wr_addr_nx;
         wr_data <= wr_data_nx;
      end
   end

   // Next-state logic; a line start always wins over a coincident dclk fall.
   always_comb begin
      state_nx   = state;
      row_nx     = row;
      nib_nx     = nib_cnt;
      n0_nx      = n0;
      m_last_nx  = m_last;
      m_seen_nx  = m_seen;
      err_nx     = err;
      wr_en_nx   = 1'b0;
      wr_addr_nx = wr_addr;
      wr_data_nx = wr_data;
      frame_done = 1'b0;

      if (lp_rise) begin
         if (flm_lvl) begin
            frame_done = (state == ST_IDLE) && (row == LAST_ROW);
            if (m_seen && (m_lvl == m_last)) begin
               err_nx[ERR_M_STUCK] = 1'b1;
            end
            m_last_nx = m_lvl;
            m_seen_nx = 1'b1;
            state_nx  = ST_LINE;
            row_nx    = '0;
            nib_nx    = '0;
         end else if (state != ST_SYNC) begin
            if (row == LAST_ROW) begin
               err_nx[ERR_ROW_OVF] = 1'b1;
               state_nx            = ST_SYNC;
            end else begin
               row_nx   = row + 1'b1;
               nib_nx   = '0;
               state_nx = ST_LINE;
            end
         end
      end else if (dclk_fall) begin
         if (state == ST_LINE) begin
            nib_nx = nib_cnt + 1'b1;
            if (!nib_cnt[0]) begin
               n0_nx = data_s2;
            end else begin
               wr_en_nx   = 1'b1;
               wr_data_nx = bit_rev8({n0, data_s2});
               wr_addr_nx = 32'(row) * BYTES_PER_ROW + 32'(nib_cnt >> 1);
            end
            if (nib_nx == LINE_END) begin
               state_nx = ST_IDLE;
            end
         end else if (state == ST_IDLE) begin
            err_nx[ERR_OVERRUN] = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_lcd_capture.sv
// Self-checking bench for lcd_capture: table vectors, corner sequences,
// and randomized lines against a line/pixel-level reference model.
module tb_lcd_capture;

   localparam int RES_X = 320;
   localparam int RES_Y = 240;
   localparam int NIBS  = RES_X / 4;
   localparam int BPR   = RES_X / 8;
   localparam int NV    = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  data;
   logic        flm, lp, dclk, m;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [7:0]  wr_data;
   logic        frame_done;
   logic [2:0]  err;

   lcd_capture #(.RES_X(RES_X), .RES_Y(RES_Y)) dut (
      .clk(clk), .rst(rst), .data(data), .flm(flm), .lp(lp), .dclk(dclk),
      .m(m), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .frame_done(frame_done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  data;
   } wr_t;

   typedef struct {
      logic [3:0] n0;
      logic [3:0] n1;
      logic [7:0] exp;
   } vec_t;

   wr_t  got_q[$];
   wr_t  exp_q[$];
   vec_t vec[NV];
   int   checks   = 0;
   int   failures = 0;
   int   fd_got   = 0;

   // reference model state
   bit         md_in;
   int         md_row;
   int         md_nibs;
   int         md_n0;
   bit         md_seen;
   bit         md_mlast;
   logic [2:0] md_err;
   int         md_fd;

   always @(negedge clk) begin
      if (wr_en) got_q.push_back(wr_t'{addr: wr_addr, data: wr_data});
      if (frame_done) fd_got++;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Leftmost pixel (MSB of the first nibble) lands in bit 0 of the byte.
   function automatic logic [7:0] pixel_byte(input int hi, input int lo);
      int v;
      int r;
      v = hi * 16 + lo;
      r = 0;
      for (int i = 0; i < 8; i++) begin
         if (((v >> i) & 1) != 0) r += (1 << (7 - i));
      end
      return r[7:0];
   endfunction

   task automatic mdl_rst();
      md_in = 0; md_row = 0; md_nibs = 0; md_n0 = 0;
      md_seen = 0; md_mlast = 0; md_err = '0; md_fd = 0; fd_got = 0;
      exp_q.delete();
   endtask

   task automatic mdl_lp(input bit f, input bit mv);
      if (f) begin
         if (md_in && md_row == RES_Y - 1 && md_nibs == NIBS) md_fd++;
         if (md_seen && mv == md_mlast) md_err[2] = 1'b1;
         md_mlast = mv; md_seen = 1;
         md_in = 1; md_row = 0; md_nibs = 0;
      end else if (md_in) begin
         if (md_row == RES_Y - 1) begin
            md_err[1] = 1'b1;
            md_in = 0;
         end else begin
            md_row++;
            md_nibs = 0;
         end
      end
   endtask

   task automatic mdl_nib(input int d);
      if (!md_in) return;
      if (md_nibs >= NIBS) begin
         md_err[0] = 1'b1;
         return;
      end
      if (md_nibs % 2 == 0) md_n0 = d;
      else exp_q.push_back(wr_t'{addr: 32'(md_row * BPR + md_nibs / 2),
                                 data: pixel_byte(md_n0, d)});
      md_nibs++;
   endtask

   task automatic drv_lp(input bit f, input bit mv);
      flm = f; m = mv; lp = 1'b1;
      repeat (3) @(negedge clk);
      lp = 1'b0;
      repeat (3) @(negedge clk);
      mdl_lp(f, mv);
   endtask

   task automatic drv_nib(input logic [3:0] d);
      data = d; dclk = 1'b1;
      repeat (2) @(negedge clk);
      dclk = 1'b0;
      repeat (2) @(negedge clk);
      mdl_nib(int'(d));
   endtask

   task automatic drv_line(input bit f, input bit mv, input int n);
      drv_lp(f, mv);
      for (int i = 0; i < n; i++) drv_nib(4'($urandom_range(0, 15)));
   endtask

   task automatic settle();
      repeat (6) @(negedge clk);
   endtask

   task automatic cmp_model(input string tag);
      int n;
      chk({tag, "_nwr"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk({tag, "_addr"}, got_q[i].addr, exp_q[i].addr);
         chk({tag, "_data"}, got_q[i].data, exp_q[i].data);
      end
      chk({tag, "_err"}, err, md_err);
      chk({tag, "_fdone"}, fd_got, md_fd);
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      vec[0] = '{4'h8, 4'h0, 8'h01};
      vec[1] = '{4'h3, 4'hC, 8'h3C};
      vec[2] = '{4'h1, 4'h0, 8'h08};
      vec[3] = '{4'h0, 4'h1, 8'h80};
      vec[4] = '{4'hF, 4'h0, 8'h0F};
      vec[5] = '{4'hA, 4'h5, 8'hA5};
      vec[6] = '{4'hC, 4'h8, 8'h13};
      vec[7] = '{4'h6, 4'h1, 8'h86};

      rst = 1'b1; flm = 0; lp = 0; dclk = 0; m = 0; data = '0;
      mdl_rst();
      repeat (3) @(negedge clk);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_err", err, 0);
      rst = 1'b0;
      @(negedge clk);

      // lines before any flm are ignored
      for (int l = 0; l < 3; l++) drv_line(1'b0, 1'b0, 6);
      settle();
      chk("presync_nwr", got_q.size(), 0);
      cmp_model("presync");

      // table vectors on row 0
      drv_lp(1'b1, 1'b0);
      for (int i = 0; i < NV; i++) begin
         drv_nib(vec[i].n0);
         drv_nib(vec[i].n1);
      end
      settle();
      chk("tbl_nwr", got_q.size(), NV);
      for (int i = 0; i < NV && i < got_q.size(); i++) begin
         chk("tbl_addr", got_q[i].addr, i);
         chk("tbl_data", got_q[i].data, vec[i].exp);
      end
      cmp_model("tbl");
      for (int i = 2 * NV; i < NIBS; i++) drv_nib(4'($urandom_range(0, 15)));
      settle();
      cmp_model("line0");

      // row 1 with a known byte at index 5
      drv_lp(1'b0, 1'b0);
      for (int i = 0; i < NIBS; i++) begin
         if (i == 10) drv_nib(4'h3);
         else if (i == 11) drv_nib(4'hC);
         else drv_nib(4'($urandom_range(0, 15)));
      end
      settle();
      chk("l1_nwr", got_q.size(), BPR);
      if (got_q.size() > 5) begin
         chk("l1_addr5", got_q[5].addr, 45);
         chk("l1_data5", got_q[5].data, 8'h3C);
      end
      cmp_model("line1");

      // 81 nibbles: overrun
      drv_line(1'b0, 1'b0, NIBS + 1);
      settle();
      chk("l2_nwr", got_q.size(), BPR);
      chk("overrun", err[0], 1);
      cmp_model("line2");

      // finish the frame, last row full, then flm with m unchanged
      for (int r = 3; r < RES_Y - 1; r++) drv_lp(1'b0, 1'b0);
      drv_line(1'b0, 1'b0, NIBS);
      drv_lp(1'b1, 1'b0);
      for (int i = 0; i < 5; i++) drv_nib(4'($urandom_range(0, 15)));
      settle();
      chk("frame_done_cnt", fd_got, 1);
      chk("m_stuck", err[2], 1);
      chk("overrun_sticky", err[0], 1);
      cmp_model("frame");

      // short line 0 left a lone N0; row 1 must start clean
      drv_line(1'b0, 1'b0, NIBS);
      settle();
      chk("short_nwr", got_q.size(), BPR);
      if (got_q.size() > 0) chk("short_addr0", got_q[0].addr, BPR);
      cmp_model("short");

      // row overflow on the 241st line start
      for (int r = 2; r < RES_Y; r++) drv_lp(1'b0, 1'b0);
      drv_line(1'b0, 1'b0, 6);
      drv_line(1'b0, 1'b0, 6);
      settle();
      chk("rowovf_err", err[1], 1);
      chk("rowovf_nwr", got_q.size(), 0);
      cmp_model("rowovf");
      drv_line(1'b1, 1'b1, 4);
      settle();
      chk("resume_nwr", got_q.size(), 2);
      if (got_q.size() > 0) chk("resume_addr0", got_q[0].addr, 0);
      cmp_model("resume");

      // dclk fall coincident with lp rise: nibble discarded
      drv_lp(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) drv_nib(4'($urandom_range(0, 15)));
      data = 4'($urandom_range(0, 15)); dclk = 1'b1;
      repeat (2) @(negedge clk);
      flm = 1'b0; lp = 1'b1; dclk = 1'b0;
      repeat (3) @(negedge clk);
      lp = 1'b0;
      repeat (3) @(negedge clk);
      mdl_lp(1'b0, 1'b1);
      drv_nib(4'h8);
      drv_nib(4'h0);
      settle();
      chk("coinc_nwr", got_q.size(), 2);
      if (got_q.size() == 2) begin
         chk("coinc_addr", got_q[1].addr, 2 * BPR);
         chk("coinc_data", got_q[1].data, 8'h01);
      end
      cmp_model("coinc");

      // reset in the middle of nibble 5
      drv_lp(1'b0, 1'b1);
      for (int i = 0; i < 5; i++) drv_nib(4'($urandom_range(0, 15)));
      settle();
      cmp_model("prerst");
      data = 4'hF; dclk = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      dclk = 1'b0;
      repeat (2) @(negedge clk);
      chk("mrst_wr_en", wr_en, 0);
      chk("mrst_wr_addr", wr_addr, 0);
      chk("mrst_wr_data", wr_data, 0);
      chk("mrst_frame_done", frame_done, 0);
      chk("mrst_err", err, 0);
      chk("mrst_nwr", got_q.size(), 0);
      mdl_rst();
      rst = 1'b0;
      @(negedge clk);
      drv_line(1'b0, 1'b0, 6);
      settle();
      chk("postrst_nwr", got_q.size(), 0);
      cmp_model("postrst");
      drv_line(1'b1, 1'b1, 8);
      settle();
      chk("postrst_err", err, 0);
      if (got_q.size() > 0) chk("postrst_addr0", got_q[0].addr, 0);
      cmp_model("postflm");

      // randomized lines
      for (int l = 0; l < 50; l++) begin
         drv_line(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                  $urandom_range(0, NIBS + 4));
         settle();
         cmp_model("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lcd_capture.md
LCD_CAPTURE -- requirements
Module: lcd_capture

Interface
REQ-001 Parameter RES_X, default 320: panel width in pixels; SHALL be a multiple of 8.
REQ-002 Parameter RES_Y, default 240: panel height in lines.
REQ-003 clk  in  1  system clock; one clock domain; all flops on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 data  in  4  panel nibble bus, stable while dclk high and the following low phase.
REQ-006 flm  in  1  first-line marker, high for the whole of line 0.
REQ-007 lp  in  1  line pulse, one pixel-clock source period high at each line start.
REQ-008 dclk  in  1  nibble strobe.
REQ-009 m  in  1  AC drive signal, toggles once per frame.
REQ-010 wr_en  out  1  framebuffer byte write strobe, one clk wide.
REQ-011 wr_addr  out  32  byte address = row*(RES_X/8)+byte index.
REQ-012 wr_data  out  8  reconstructed framebuffer byte.
REQ-013 frame_done  out  1  one-clk pulse when a frame of RES_Y lines completes.
REQ-014 err  out  3  sticky flags: [0] overrun, [1] row overflow, [2] m not toggled.

Function
REQ-015 flm, lp, dclk, m, data SHALL pass through 2-flop synchronizers; clk SHALL be at least 4x the panel source clock.
REQ-016 Edges SHALL be detected on synchronized signals: lp rise, lp fall, dclk fall.
REQ-017 States: SYNC, LINE, IDLE; reset state SYNC.
REQ-018 SYNC: on lp rise with flm=1 -> LINE, row=0, nibble count=0; lp rise with flm=0 is ignored; no writes in SYNC.
REQ-019 LINE/IDLE: on lp rise with flm=1 -> row=0; with flm=0 -> row+1; nibble count=0; enter LINE.
REQ-020 In LINE, each dclk fall SHALL capture the synchronized nibble; even-indexed capture is N0, odd-indexed is N1.
REQ-021 After N1, wr_data SHALL equal bit-reverse of {N0,N1} (wr_data[0]=N0[3] ... wr_data[7]=N1[0]), with wr_en high exactly one clk, 1 cycle after the dclk fall.
REQ-022 wr_addr SHALL use byte index = nibble count/2, computed in 32 bits with no truncation.
REQ-023 At nibble count = RES_X/4, LINE -> IDLE; further dclk falls before the next lp SHALL set err[0] and produce no writes.
REQ-024 lp rise with flm=0 when row = RES_Y-1 SHALL set err[1]; state -> SYNC, no writes until the next flm line.
REQ-025 lp rise with flm=1 when the previous frame reached row RES_Y-1 and its last line completed all RES_X/4 nibbles SHALL pulse frame_done the same cycle.
REQ-026 On each flm line start, m SHALL differ from the m latched at the previous flm line start, else set err[2]; no check on the first frame after reset.
REQ-027 lp rise mid-line (short line) SHALL drop any lone N0 without a write and start the new line normally.
REQ-028 Simultaneous dclk fall and lp rise: the lp rise takes priority; the nibble is discarded.

Reset
REQ-029 While rst is high: wr_en=0, wr_addr=0, wr_data=0, frame_done=0, err=0, row=0, nibble count=0, synchronizers=0, state SYNC.
REQ-030 Reset asserted mid-line SHALL abort the line with no partial write; after release, capture resumes only at the next flm line.

Structure
REQ-031 RES_X/RES_Y defaults, state encodings, and err bit indices SHALL reside in the shared lcd params include used by the LCD driver.
REQ-032 One sub-module lcd_sync_edge SHALL be used (2-flop sync plus rise/fall pulse), one instance per control input; data SHALL use plain 2-flop sync.

Verification
REQ-033 Reset, flm line with first nibbles 4'b1000 then 4'b0000 -> wr_en once, wr_addr=0, wr_data=0x01.
REQ-034 Line 1, nibbles 10/11 = 4'h3/4'hC -> wr_addr=45, wr_data=0x3C; 40 writes per line total.
REQ-035 81 nibbles in one line -> exactly 40 writes, err[0]=1, stays 1 until rst.
REQ-036 Two frames with m unchanged at flm -> err[2]=1; full 240-line frame followed by flm -> frame_done one pulse.
REQ-037 After rst, three lp lines with flm=0, then an flm line -> zero writes before the flm line, writes from addr 0 after it.
REQ-038 241st lp without flm -> err[1]=1, no writes until the next flm; rst asserted at nibble 5 -> all outputs 0, no write for the partial byte.
